// File: rtl/bcd_display_scanner_pkg.sv
// rtl/bcd_display_scanner_pkg.sv - shared definitions for the two-digit 7-segment scanner
// Purpose: scan state encoding, blank segment constant, segment pattern table
//          and a BCD range helper shared by the scanner and its decoder.
// Ports:   none (package).
package bcd_display_scanner_pkg;

  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_GAP_U = 2'd1,
    S_TENS  = 2'd2,
    S_GAP_T = 2'd3
  } scan_state_t;

  // Segment vectors are ordered a..g with index 0 = segment a.
  localparam logic [0:6] SEG_BLANK = 7'b0000000;

  // Index 0 of the packed [0:9] array is the leftmost concatenation element.
  localparam logic [0:9][0:6] SEG_TABLE = {
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011   // 9
  };

  function automatic logic bcd_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to 7-segment pattern decoder
// Purpose: map one BCD digit to its a..g segment pattern; codes above 9 give all-off.
// Ports:   bcd  in  [3:0]  digit to decode
//          seg  out [0:6]  segments a..g, seg[0]=a, active-high
module bcd_to_seg7
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd_valid(bcd)) begin
      seg = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - time-multiplexed two-digit 7-segment display scanner
// Purpose: capture tens/units BCD digits on a load strobe into a shadow register,
//          transfer them to the displayed digits once per scan at the start of the
//          units phase, and scan them onto a shared segment bus with blank gaps.
// Ports:   clk        in   1      rising-edge clock
//          reset      in   1      synchronous, active-high
//          load       in   1      capture tens_bcd/units_bcd this cycle
//          tens_bcd   in   [3:0]  tens digit
//          units_bcd  in   [3:0]  units digit
//          seg        out  [0:6]  segments a..g (inverted when SEG_ACTIVE_LOW)
//          digit_en   out  [1:0]  one-hot enable, [0]=units [1]=tens, 00=dark
//          bcd_err    out  1      sticky, a load presented a digit above 9
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV    = 4,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] tens_bcd,
  input  logic [3:0] units_bcd,
  output logic [0:6] seg,
  output logic [1:0] digit_en,
  output logic       bcd_err
);

  localparam int              PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);

  scan_state_t   state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    shadow_tens, shadow_units;
  logic [3:0]    active_tens, active_units;
  logic          bcd_err_q;
  logic          load_ok;
  logic          transfer;
  logic [3:0]    show_digit;
  logic [0:6]    seg_dec;
  logic [0:6]    seg_pre;

  assign load_ok  = load & bcd_valid(tens_bcd) & bcd_valid(units_bcd);
  // The only edge leaving S_GAP_T goes into S_UNITS, so this marks the transfer edge.
  assign transfer = (state_q == S_GAP_T);

  // Next state / prescaler. The prescaler falls back to zero whenever the state changes.
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    case (state_q)
      S_UNITS: begin
        if (presc_q == PRESC_LAST) state_d = S_GAP_U;
        else                       presc_d = presc_q + 1'b1;
      end
      S_GAP_U: state_d = S_TENS;
      S_TENS: begin
        if (presc_q == PRESC_LAST) state_d = S_GAP_T;
        else                       presc_d = presc_q + 1'b1;
      end
      S_GAP_T: state_d = S_UNITS;
      default: state_d = S_GAP_T;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_GAP_T;
      presc_q      <= '0;
      shadow_tens  <= '0;
      shadow_units <= '0;
      active_tens  <= '0;
      active_units <= '0;
      bcd_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      if (load_ok) begin
        shadow_tens  <= tens_bcd;
        shadow_units <= units_bcd;
      end
      if (load && !load_ok) begin
        bcd_err_q <= 1'b1;
      end
      // A valid load coinciding with the transfer bypasses the shadow.
      if (transfer) begin
        active_tens  <= load_ok ? tens_bcd  : shadow_tens;
        active_units <= load_ok ? units_bcd : shadow_units;
      end
    end
  end

  assign show_digit = (state_q == S_TENS) ? active_tens : active_units;

  bcd_to_seg7 u_dec (
    .bcd (show_digit),
    .seg (seg_dec)
  );

  always_comb begin
    digit_en = 2'b00;
    seg_pre  = SEG_BLANK;
    case (state_q)
      S_UNITS: begin
        digit_en = 2'b01;
        seg_pre  = seg_dec;
      end
      S_TENS: begin
        digit_en = 2'b10;
        // Leading-zero blanking keeps the enable asserted so the scan timing is unchanged.
        if (!((BLANK_LEADING != 0) && (active_tens == 4'd0))) seg_pre = seg_dec;
      end
      default: begin
        digit_en = 2'b00;
        seg_pre  = SEG_BLANK;
      end
    endcase
  end

  assign seg     = (SEG_ACTIVE_LOW != 0) ? ~seg_pre : seg_pre;
  assign bcd_err = bcd_err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       load0 = 1'b0, load1 = 1'b0;
  logic [3:0] t0 = 4'd0, u0 = 4'd0, t1 = 4'd0, u1 = 4'd0;
  logic [0:6] seg0, seg1;
  logic [1:0] de0, de1;
  logic       err0, err1;

  bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .load(load0), .tens_bcd(t0), .units_bcd(u0),
    .seg(seg0), .digit_en(de0), .bcd_err(err0)
  );

  bcd_display_scanner #(.REFRESH_DIV(2), .BLANK_LEADING(0), .SEG_ACTIVE_LOW(1)) dut_al (
    .clk(clk), .reset(reset), .load(load1), .tens_bcd(t1), .units_bcd(u1),
    .seg(seg1), .digit_en(de1), .bcd_err(err1)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  logic [0:6] tab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Reference model: position inside the scan period, counted with plain modular arithmetic.
  // Positions 0..R-1 units lit, R gap, R+1..2R tens lit, 2R+1 gap before the next period.
  int rdiv [2] = '{4, 2};
  bit bl   [2] = '{1'b1, 1'b0};
  bit al   [2] = '{1'b0, 1'b1};
  int m_p  [2] = '{0, 0};
  int m_sht[2] = '{0, 0};
  int m_shu[2] = '{0, 0};
  int m_act[2] = '{0, 0};
  int m_acu[2] = '{0, 0};
  bit m_err[2] = '{1'b0, 1'b0};

  task automatic model_step(input int i, input logic rst, input logic ld,
                            input logic [3:0] t, input logic [3:0] u);
    int  last;
    bit  ok;
    last = 2 * rdiv[i] + 1;
    if (rst) begin
      m_p[i] = last; m_sht[i] = 0; m_shu[i] = 0; m_act[i] = 0; m_acu[i] = 0; m_err[i] = 1'b0;
    end else begin
      ok = ld && (t <= 9) && (u <= 9);
      if (ld && !ok) m_err[i] = 1'b1;
      if (m_p[i] == last) begin
        m_act[i] = ok ? int'(t) : m_sht[i];
        m_acu[i] = ok ? int'(u) : m_shu[i];
      end
      if (ok) begin
        m_sht[i] = int'(t);
        m_shu[i] = int'(u);
      end
      m_p[i] = (m_p[i] + 1) % (last + 1);
    end
  endtask

  function automatic logic [1:0] exp_en(input int i);
    if (m_p[i] < rdiv[i]) return 2'b01;
    if (m_p[i] > rdiv[i] && m_p[i] <= 2 * rdiv[i]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [0:6] exp_seg(input int i);
    logic [0:6] s;
    s = 7'b0000000;
    if (m_p[i] < rdiv[i]) s = tab[m_acu[i]];
    else if (m_p[i] > rdiv[i] && m_p[i] <= 2 * rdiv[i])
      s = (bl[i] && m_act[i] == 0) ? 7'b0000000 : tab[m_act[i]];
    return al[i] ? ~s : s;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) passed++;
    else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, want);
  endtask

  task automatic check_inst(input int i);
    if (i == 0) begin
      chk("en0", {6'b0, de0}, {6'b0, exp_en(0)});
      chk("seg0", {1'b0, seg0}, {1'b0, exp_seg(0)});
      chk("err0", {7'b0, err0}, {7'b0, m_err[0]});
    end else begin
      chk("en1", {6'b0, de1}, {6'b0, exp_en(1)});
      chk("seg1", {1'b0, seg1}, {1'b0, exp_seg(1)});
      chk("err1", {7'b0, err1}, {7'b0, m_err[1]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(0, reset, load0, t0, u0);
    model_step(1, reset, load1, t1, u1);
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic wait_phase(input int i, input int target);
    for (int k = 0; k < 40 && m_p[i] != target; k++) tick();
  endtask

  task automatic do_load(input int i, input logic [3:0] t, input logic [3:0] u);
    if (i == 0) begin load0 = 1'b1; t0 = t; u0 = u; end
    else        begin load1 = 1'b1; t1 = t; u1 = u; end
    tick();
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  initial begin
    // Test 1: reset, then one full default scan with the tens zero blanked.
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_en", {6'b0, de0}, 8'd0);
    chk("rst_seg", {1'b0, seg0}, 8'd0);
    chk("rst_err", {7'b0, err0}, 8'd0);
    reset = 1'b0;
    tick();
    chk("first_units_en", {6'b0, de0}, 8'b01);
    chk("first_units_seg", {1'b0, seg0}, {1'b0, 7'b1111110});
    repeat (9) tick();
    chk("period10_gap", {6'b0, de0}, 8'b00);

    // Test 2: load during units phase is deferred to the next scan.
    wait_phase(0, 0);
    do_load(0, 4'd4, 4'd2);
    chk("deferred_units", {1'b0, seg0}, {1'b0, 7'b1111110});
    wait_phase(0, 0);
    chk("units_2", {1'b0, seg0}, {1'b0, 7'b1101101});
    wait_phase(0, 5);
    chk("tens_4", {1'b0, seg0}, {1'b0, 7'b0110011});

    // Test 3: load on the transfer edge goes straight to the display.
    wait_phase(0, 9);
    do_load(0, 4'd9, 4'd9);
    chk("bypass_units_9", {1'b0, seg0}, {1'b0, 7'b1111011});

    // Test 4: invalid load sets sticky error and leaves the display alone.
    tick();
    do_load(0, 4'd10, 4'd3);
    chk("err_set", {7'b0, err0}, 8'd1);
    wait_phase(0, 0);
    chk("err_keeps_old", {1'b0, seg0}, {1'b0, 7'b1111011});
    do_load(0, 4'd6, 4'd1);
    wait_phase(0, 0);
    chk("valid_after_err", {1'b0, seg0}, {1'b0, 7'b0110000});
    chk("err_sticky", {7'b0, err0}, 8'd1);
    reset = 1'b1;
    tick();
    chk("err_cleared", {7'b0, err0}, 8'd0);
    reset = 1'b0;

    // Test 5: reset in the middle of the tens phase.
    do_load(0, 4'd5, 4'd7);
    wait_phase(0, 0);
    wait_phase(0, 6);
    chk("mid_tens_5", {1'b0, seg0}, {1'b0, 7'b1011011});
    reset = 1'b1;
    tick();
    chk("midrst_en", {6'b0, de0}, 8'd0);
    chk("midrst_seg", {1'b0, seg0}, 8'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_units", {1'b0, seg0}, {1'b0, 7'b1111110});

    // Test 6: no leading blank, inverted segments, REFRESH_DIV=2.
    do_load(1, 4'd0, 4'd8);
    wait_phase(1, 5);
    wait_phase(1, 0);
    chk("al_units_8", {1'b0, seg1}, {1'b0, 7'b0000000});
    wait_phase(1, 2);
    chk("al_gap", {1'b0, seg1}, {1'b0, 7'b1111111});
    wait_phase(1, 3);
    chk("al_tens_0", {1'b0, seg1}, {1'b0, 7'b0000001});
    chk("al_tens_en", {6'b0, de1}, 8'b10);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      load0 = ($urandom_range(0, 2) == 0);
      load1 = ($urandom_range(0, 2) == 0);
      t0 = 4'($urandom_range(0, 10));
      u0 = 4'($urandom_range(0, 10));
      t1 = 4'($urandom_range(0, 10));
      u1 = 4'($urandom_range(0, 10));
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
